// File: rtl/alu_operand_stage_pkg.sv
// Shared types and constants for the decode/execute operand stage.
package alu_operand_stage_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;

    // Meaning of each source slot feeding an operand mux.
    typedef enum logic [1:0] {
        SRC_REG   = 2'd0,
        SRC_IMM   = 2'd1,
        SRC_PC    = 2'd2,
        SRC_CONST = 2'd3
    } src_idx_e;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Bus between decode/register-read, the operand stage and the ALU.
//
// Handshake: a request moves upstream -> stage on a rising edge where
// IN_VALID & IN_READY are both high; a pair moves stage -> ALU on a rising
// edge where OUT_VALID & OUT_READY are both high. A valid, once raised, keeps
// its payload stable until taken. IN_READY never depends combinationally on
// OUT_READY.
interface alu_operand_stage_if
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_SRC = 4
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic                    IN_VALID;
    logic                    IN_READY;
    logic [SEL_W-1:0]        A_SEL;
    logic [SEL_W-1:0]        B_SEL;
    logic [NUM_SRC*XLEN-1:0] SRC_A;
    logic [NUM_SRC*XLEN-1:0] SRC_B;
    logic [REG_ADDR_W-1:0]   RS1_ADDR;
    logic [REG_ADDR_W-1:0]   RS2_ADDR;
    logic                    FWD_VALID;
    logic [REG_ADDR_W-1:0]   FWD_ADDR;
    logic [XLEN-1:0]         FWD_DATA;
    logic                    OUT_VALID;
    logic                    OUT_READY;
    logic [XLEN-1:0]         OP_A;
    logic [XLEN-1:0]         OP_B;
    logic                    SEL_ERR;

    // Side that drives requests and consumes pairs (decode + ALU).
    modport master (
        output IN_VALID, A_SEL, B_SEL, SRC_A, SRC_B, RS1_ADDR, RS2_ADDR,
               FWD_VALID, FWD_ADDR, FWD_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, OP_A, OP_B, SEL_ERR
    );

    // The operand stage itself.
    modport slave (
        input  IN_VALID, A_SEL, B_SEL, SRC_A, SRC_B, RS1_ADDR, RS2_ADDR,
               FWD_VALID, FWD_ADDR, FWD_DATA, OUT_READY,
        output IN_READY, OUT_VALID, OP_A, OP_B, SEL_ERR
    );

endinterface

// File: rtl/alu_operand_stage_operand_select.sv
// Combinational select for one ALU operand: packed-source mux, range check
// and register-forwarding override on the register-read slot.
module operand_select
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC*XLEN-1:0]       srcs,
    input  logic [$clog2(NUM_SRC)-1:0]    sel,
    input  logic [REG_ADDR_W-1:0]         rs_addr,
    input  logic                          fwd_valid,
    input  logic [REG_ADDR_W-1:0]         fwd_addr,
    input  logic [XLEN-1:0]               fwd_data,
    output logic [XLEN-1:0]               operand,
    output logic                          sel_err
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic fwd_hit;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    assign fwd_hit = (sel == SEL_W'(SRC_REG)) && fwd_valid &&
                     (fwd_addr == rs_addr) && (rs_addr != '0);

    // Mux the chosen source; a select that matches no slot yields zero and flags an error.
    always_comb begin
        operand = '0;
        sel_err = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                operand = srcs[i*XLEN +: XLEN];
                sel_err = 1'b0;
            end
        end
        if (fwd_hit) begin
            operand = fwd_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode -> execute boundary: selects both ALU operands (with forwarding)
// and holds them in a two-entry skid buffer behind a valid/ready handshake.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_SRC = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    alu_operand_stage_if.slave    bus,
    output skid_state_e           STATE_DBG
);
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic            err_a;
    logic            err_b;

    logic            accept;
    logic            deliver;

    skid_state_e     state;
    logic [XLEN-1:0] head_a;
    logic [XLEN-1:0] head_b;
    logic [XLEN-1:0] skid_a;
    logic [XLEN-1:0] skid_b;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            sel_err_q;

    operand_select #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) u_sel_a (
        .srcs      (bus.SRC_A),
        .sel       (bus.A_SEL),
        .rs_addr   (bus.RS1_ADDR),
        .fwd_valid (bus.FWD_VALID),
        .fwd_addr  (bus.FWD_ADDR),
        .fwd_data  (bus.FWD_DATA),
        .operand   (sel_a),
        .sel_err   (err_a)
    );

    operand_select #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) u_sel_b (
        .srcs      (bus.SRC_B),
        .sel       (bus.B_SEL),
        .rs_addr   (bus.RS2_ADDR),
        .fwd_valid (bus.FWD_VALID),
        .fwd_addr  (bus.FWD_ADDR),
        .fwd_data  (bus.FWD_DATA),
        .operand   (sel_b),
        .sel_err   (err_b)
    );

    // Ready comes from a register, so OUT_READY has no path to IN_READY;
    // it is forced low while reset is held.
    assign bus.IN_READY  = in_ready_q & ~RST;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OP_A      = head_a;
    assign bus.OP_B      = head_b;
    assign bus.SEL_ERR   = sel_err_q;
    assign STATE_DBG     = state;

    assign accept  = bus.IN_VALID & bus.IN_READY;
    assign deliver = out_valid_q & bus.OUT_READY;

    // Skid-buffer FSM: head entry drives the outputs, skid entry absorbs one
    // extra pair when the ALU stalls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_EMPTY;
            head_a      <= '0;
            head_b      <= '0;
            skid_a      <= '0;
            skid_b      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head_a      <= sel_a;
                        head_b      <= sel_b;
                        out_valid_q <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        head_a <= sel_a;
                        head_b <= sel_b;
                    end else if (accept) begin
                        skid_a     <= sel_a;
                        skid_b     <= sel_b;
                        in_ready_q <= 1'b0;
                        state      <= ST_TWO;
                    end else if (deliver) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (deliver) begin
                        head_a     <= skid_a;
                        head_b     <= skid_b;
                        in_ready_q <= 1'b1;
                        state      <= ST_ONE;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // Sticky flag: any accepted request with an out-of-range select sets it until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_err_q <= 1'b0;
        end else if (accept && (err_a || err_b)) begin
            sel_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: a NUM_SRC=4 instance exercised
// through a scoreboard, plus a NUM_SRC=3 instance for select-range errors.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    localparam int W = 32;

    logic CLK;
    logic RST;
    skid_state_e st4;
    skid_state_e st3;

    int n_checks = 0;
    int n_fail   = 0;
    int n_dlv    = 0;

    logic [2*W-1:0] exp_q[$];

    alu_operand_stage_if #(.XLEN(W), .NUM_SRC(4)) bus4 ();
    alu_operand_stage_if #(.XLEN(W), .NUM_SRC(3)) bus3 ();

    alu_operand_stage #(.XLEN(W), .NUM_SRC(4)) dut4 (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus4),
        .STATE_DBG (st4)
    );

    alu_operand_stage #(.XLEN(W), .NUM_SRC(3)) dut3 (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus3),
        .STATE_DBG (st3)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*W-1:0] pack4(input logic [W-1:0] s0, s1, s2, s3);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [3*W-1:0] pack3(input logic [W-1:0] s0, s1, s2);
        return {s2, s1, s0};
    endfunction

    // One clock of bus4, called at a falling edge with inputs already driven.
    // Scoreboard: accepted requests push their expected pair, deliveries pop and compare.
    task automatic step(input logic [W-1:0] exp_a, input logic [W-1:0] exp_b);
        logic [2*W-1:0] e;
        #1;
        if (bus4.IN_VALID && bus4.IN_READY) begin
            exp_q.push_back({exp_b, exp_a});
        end
        if (bus4.OUT_VALID && bus4.OUT_READY) begin
            n_dlv++;
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("op_a", 64'(bus4.OP_A), 64'(e[W-1:0]));
                check("op_b", 64'(bus4.OP_B), 64'(e[2*W-1:W]));
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle4();
        bus4.IN_VALID  = 1'b0;
        bus4.A_SEL     = '0;
        bus4.B_SEL     = '0;
        bus4.SRC_A     = '0;
        bus4.SRC_B     = '0;
        bus4.RS1_ADDR  = '0;
        bus4.RS2_ADDR  = '0;
        bus4.FWD_VALID = 1'b0;
        bus4.FWD_ADDR  = '0;
        bus4.FWD_DATA  = '0;
    endtask

    initial begin
        int dlv0;
        int rdy_low;
        logic [W-1:0] ea;
        logic [W-1:0] eb;

        RST = 1'b1;
        idle4();
        bus4.OUT_READY = 1'b1;
        bus3.IN_VALID  = 1'b0;
        bus3.A_SEL     = '0;
        bus3.B_SEL     = '0;
        bus3.SRC_A     = '0;
        bus3.SRC_B     = '0;
        bus3.RS1_ADDR  = '0;
        bus3.RS2_ADDR  = '0;
        bus3.FWD_VALID = 1'b0;
        bus3.FWD_ADDR  = '0;
        bus3.FWD_DATA  = '0;
        bus3.OUT_READY = 1'b1;

        // reset state
        repeat (3) @(negedge CLK);
        check("rst_in_ready", 64'(bus4.IN_READY), 64'd0);
        check("rst_out_valid", 64'(bus4.OUT_VALID), 64'd0);
        check("rst_op_a", 64'(bus4.OP_A), 64'd0);
        check("rst_op_b", 64'(bus4.OP_B), 64'd0);
        check("rst_sel_err", 64'(bus3.SEL_ERR), 64'd0);
        RST = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus4.IN_READY), 64'd1);
        check("post_rst_state", 64'(st4), 64'(ST_EMPTY));
        @(negedge CLK);

        // single request, latency 1
        bus4.IN_VALID = 1'b1;
        bus4.A_SEL    = 2'd1;
        bus4.B_SEL    = 2'd2;
        bus4.SRC_A    = pack4(32'h0, 32'h0000_0010, 32'h0, 32'h0);
        bus4.SRC_B    = pack4(32'h0, 32'h0, 32'h0000_0400, 32'h0);
        step(32'h10, 32'h400);
        check("single_out_valid", 64'(bus4.OUT_VALID), 64'd1);
        check("single_op_a", 64'(bus4.OP_A), 64'h10);
        idle4();
        step(32'h0, 32'h0);
        check("single_drained", 64'(bus4.OUT_VALID), 64'd0);

        // forwarding cases, back to back
        bus4.IN_VALID  = 1'b1;
        bus4.A_SEL     = 2'd0;
        bus4.B_SEL     = 2'd0;
        bus4.SRC_A     = pack4(32'h1111_1111, 32'hA, 32'hB, 32'hC);
        bus4.SRC_B     = pack4(32'h2222_2222, 32'hD, 32'hE, 32'hF);
        bus4.RS1_ADDR  = 5'd5;
        bus4.RS2_ADDR  = 5'd5;
        bus4.FWD_VALID = 1'b1;
        bus4.FWD_ADDR  = 5'd5;
        bus4.FWD_DATA  = 32'hDEAD_BEEF;
        step(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        bus4.RS1_ADDR  = 5'd0;
        bus4.RS2_ADDR  = 5'd7;
        bus4.FWD_ADDR  = 5'd0;
        step(32'h1111_1111, 32'h2222_2222);
        bus4.RS1_ADDR  = 5'd9;
        bus4.RS2_ADDR  = 5'd9;
        bus4.FWD_ADDR  = 5'd9;
        bus4.FWD_VALID = 1'b0;
        step(32'h1111_1111, 32'h2222_2222);
        bus4.FWD_VALID = 1'b1;
        bus4.A_SEL     = 2'd1;
        bus4.B_SEL     = 2'd3;
        step(32'h0000_000A, 32'h0000_000F);
        idle4();
        step(32'h0, 32'h0);
        check("fwd_drained", 64'(bus4.OUT_VALID), 64'd0);

        // backpressure: fill both entries, stall a third, then drain in order
        bus4.OUT_READY = 1'b0;
        bus4.IN_VALID  = 1'b1;
        bus4.A_SEL     = 2'd0;
        bus4.B_SEL     = 2'd3;
        bus4.SRC_A     = pack4(32'h5555_0000, 32'h0, 32'h0, 32'h0);
        bus4.SRC_B     = pack4(32'h0, 32'h0, 32'h0, 32'h0000_00B1);
        bus4.RS1_ADDR  = 5'd3;
        bus4.FWD_VALID = 1'b1;
        bus4.FWD_ADDR  = 5'd3;
        bus4.FWD_DATA  = 32'hF00D_0001;
        step(32'hF00D_0001, 32'h0000_00B1);
        bus4.A_SEL     = 2'd1;
        bus4.SRC_A     = pack4(32'h5555_0000, 32'h0000_00A2, 32'h0, 32'h0);
        bus4.SRC_B     = pack4(32'h0, 32'h0, 32'h0, 32'h0000_00B2);
        bus4.FWD_DATA  = 32'h1234_5678;
        step(32'h0000_00A2, 32'h0000_00B2);
        check("bp_in_ready_full", 64'(bus4.IN_READY), 64'd0);
        check("bp_state_two", 64'(st4), 64'(ST_TWO));
        check("bp_head_a", 64'(bus4.OP_A), 64'hF00D_0001);
        bus4.SRC_A     = pack4(32'h0, 32'h0000_00A3, 32'h0, 32'h0);
        bus4.SRC_B     = pack4(32'h0, 32'h0, 32'h0, 32'h0000_00B3);
        step(32'h0000_00A3, 32'h0000_00B3);
        check("bp_stable_a", 64'(bus4.OP_A), 64'hF00D_0001);
        check("bp_stable_b", 64'(bus4.OP_B), 64'h0000_00B1);
        check("bp_still_full", 64'(bus4.IN_READY), 64'd0);
        bus4.OUT_READY = 1'b1;
        step(32'h0000_00A3, 32'h0000_00B3);
        check("bp_ready_again", 64'(bus4.IN_READY), 64'd1);
        step(32'h0000_00A3, 32'h0000_00B3);
        idle4();
        step(32'h0, 32'h0);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        check("bp_out_valid", 64'(bus4.OUT_VALID), 64'd0);

        // streaming: 16 back-to-back requests
        dlv0    = n_dlv;
        rdy_low = 0;
        for (int i = 0; i < 16; i++) begin
            bus4.IN_VALID = 1'b1;
            bus4.A_SEL    = 2'(1 + (i % 3));
            bus4.B_SEL    = 2'(i % 4);
            bus4.SRC_A    = pack4(32'h0000_0000 + i, 32'h0000_1000 + i,
                                  32'h0000_2000 + i, 32'h0000_3000 + i);
            bus4.SRC_B    = pack4(32'h0007_0000 + i, 32'h0017_0000 + i,
                                  32'h0027_0000 + i, 32'h0037_0000 + i);
            bus4.FWD_VALID = 1'b0;
            ea = 32'h0000_1000 * (1 + (i % 3)) + i;
            eb = 32'h0010_0000 * (i % 4) + 32'h0007_0000 + i;
            if (bus4.IN_READY !== 1'b1) rdy_low++;
            step(ea, eb);
        end
        check("stream_dlv_in_loop", 64'(n_dlv - dlv0), 64'd15);
        idle4();
        step(32'h0, 32'h0);
        check("stream_dlv_total", 64'(n_dlv - dlv0), 64'd16);
        check("stream_ready_low_cycles", 64'(rdy_low), 64'd0);

        // out-of-range select on the three-source instance
        bus3.IN_VALID = 1'b1;
        bus3.A_SEL    = 2'd3;
        bus3.B_SEL    = 2'd1;
        bus3.SRC_A    = pack3(32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002);
        bus3.SRC_B    = pack3(32'hBBBB_0000, 32'hBBBB_0001, 32'hBBBB_0002);
        @(negedge CLK);
        check("oor_out_valid", 64'(bus3.OUT_VALID), 64'd1);
        check("oor_op_a", 64'(bus3.OP_A), 64'd0);
        check("oor_op_b", 64'(bus3.OP_B), 64'hBBBB_0001);
        check("oor_sel_err", 64'(bus3.SEL_ERR), 64'd1);
        for (int i = 0; i < 10; i++) begin
            bus3.A_SEL = 2'(i % 3);
            bus3.B_SEL = 2'd2;
            @(negedge CLK);
            check("oor_legal_op_a", 64'(bus3.OP_A), 64'(32'hAAAA_0000 + (i % 3)));
        end
        check("oor_sticky", 64'(bus3.SEL_ERR), 64'd1);
        bus3.IN_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("oor_cleared", 64'(bus3.SEL_ERR), 64'd0);
        @(negedge CLK);

        // reset while both entries are full
        bus4.OUT_READY = 1'b0;
        bus4.IN_VALID  = 1'b1;
        bus4.A_SEL     = 2'd1;
        bus4.B_SEL     = 2'd2;
        bus4.SRC_A     = pack4(32'h0, 32'h0000_0C01, 32'h0, 32'h0);
        bus4.SRC_B     = pack4(32'h0, 32'h0, 32'h0000_0D01, 32'h0);
        step(32'h0000_0C01, 32'h0000_0D01);
        step(32'h0000_0C01, 32'h0000_0D01);
        check("rst2_state_two", 64'(st4), 64'(ST_TWO));
        idle4();
        RST = 1'b1;
        #1;
        check("rst2_in_ready_during", 64'(bus4.IN_READY), 64'd0);
        exp_q.delete();
        @(negedge CLK);
        check("rst2_out_valid", 64'(bus4.OUT_VALID), 64'd0);
        check("rst2_in_ready_held", 64'(bus4.IN_READY), 64'd0);
        RST = 1'b0;
        #1;
        check("rst2_in_ready_after", 64'(bus4.IN_READY), 64'd1);
        @(negedge CLK);
        bus4.OUT_READY = 1'b1;
        dlv0 = n_dlv;
        repeat (3) step(32'h0, 32'h0);
        check("rst2_no_stale_dlv", 64'(n_dlv - dlv0), 64'd0);
        check("rst2_out_valid_idle", 64'(bus4.OUT_VALID), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised successor of the single-operand ALU input select: picks both ALU operands (A and B) from NUM_SRC sources each and applies register-forwarding override on the register-read source.
- Registers the selected pair into a 2-entry skid buffer with a valid/ready handshake.
- Sits between decode/register-read and the ALU. Provides the decode→execute pipeline boundary as the core moves beyond single-cycle.

Parameters:
XLEN, 32, operand width in bits
NUM_SRC, 4, sources per operand (index 0 = register-file read; 1 = immediate; 2 = PC; 3 = constant/other); legal range 2..16
SEL_W, $clog2(NUM_SRC), select width (derived, not overridden)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
IN_VALID  in  1  upstream has an operand request
IN_READY  out  1  stage can accept a request this cycle
A_SEL  in  SEL_W  source index for operand A
B_SEL  in  SEL_W  source index for operand B
SRC_A  in  NUM_SRC*XLEN  packed A sources; source i at bits [i*XLEN +: XLEN]
SRC_B  in  NUM_SRC*XLEN  packed B sources, same packing
RS1_ADDR  in  5  register index behind SRC_A source 0
RS2_ADDR  in  5  register index behind SRC_B source 0
FWD_VALID  in  1  forwarding bus carries a result
FWD_ADDR  in  5  destination register of the forwarded result
FWD_DATA  in  XLEN  forwarded result
OUT_VALID  out  1  OP_A/OP_B hold a valid pair
OUT_READY  in  1  ALU consumes the pair this cycle
OP_A  out  XLEN  selected operand A
OP_B  out  XLEN  selected operand B
SEL_ERR  out  1  sticky: an out-of-range select was accepted

Behaviour:
- Reset (RST high at a rising edge): buffer goes EMPTY; OUT_VALID=0; OP_A=OP_B=0; SEL_ERR=0; both skid entries cleared. IN_READY=0 while RST is high.
- A reset asserted mid-operation discards all buffered pairs. There is no output in flight after reset.
- Accept = IN_VALID & IN_READY. Deliver = OUT_VALID & OUT_READY.
- Selection (combinational, evaluated on accept):
  - Operand = SRC_x[sel].
  - If sel ≥ NUM_SRC, operand = 0 and SEL_ERR sets; it stays set until reset.
- Forwarding override:
  - Applies only when A_SEL==0, FWD_VALID=1, FWD_ADDR==RS1_ADDR and RS1_ADDR≠0: OP_A source becomes FWD_DATA. B has the same rule using RS2_ADDR.
  - Register x0 is never forwarded.
  - The override applies to A and B independently; both may forward the same FWD_DATA.
- Buffer state machine:
  - EMPTY: IN_READY=1, OUT_VALID=0. Accept → ONE.
  - ONE: IN_READY=1, OUT_VALID=1.
    - Accept & deliver → ONE, new pair shown.
    - Accept only → TWO, new pair goes to the skid entry.
    - Deliver only → EMPTY.
  - TWO: IN_READY=0, OUT_VALID=1. Deliver → ONE, skid entry moves to the head.
- IN_READY is a function of state only, with no combinational path from OUT_READY.
- Latency: accept in cycle n → OUT_VALID with that pair in cycle n+1 when EMPTY. Throughput is 1 pair/cycle while OUT_READY=1.
- Ordering is strict FIFO. Pairs are never dropped or duplicated.
- OP_A/OP_B are stable while OUT_VALID=1 and OUT_READY=0.
- OP_A/OP_B hold their last value when EMPTY; that value is don't-care for checkers.
- Forward data is sampled at accept time only. A later FWD_* change does not alter a buffered pair.

Decomposition:
- Shared package (core_pkg):
  - XLEN default.
  - REG_ADDR_W=5.
  - Enum of source indices: SRC_REG=0, SRC_IMM=1, SRC_PC=2, SRC_CONST=3.
  - Skid state enum {EMPTY, ONE, TWO}.
- One natural sub-module: operand_select. It is combinational and handles one operand: packed-source mux, range check, forwarding compare and override. It is instantiated twice (A and B).
- The skid buffer and SEL_ERR logic live in the top.

Test Plan:
- Reset then single request: A_SEL=1 (imm 0x0000_0010), B_SEL=2 (PC 0x0000_0400), OUT_READY=1 → next cycle OUT_VALID=1, OP_A=0x10, OP_B=0x400; following cycle OUT_VALID=0.
- Forwarding: A_SEL=0, RS1_ADDR=5, SRC_A[0]=0x1111_1111, FWD_VALID=1, FWD_ADDR=5, FWD_DATA=0xDEAD_BEEF → OP_A=0xDEADBEEF. Repeat with RS1_ADDR=0 and FWD_ADDR=0 → OP_A=0x11111111.
- Backpressure: OUT_READY=0, push pairs P1, P2 on consecutive cycles → IN_READY drops to 0 after P2 and a third push is stalled. Raise OUT_READY → P1, P2, P3 delivered in order, one per cycle, OP stable while stalled.
- Streaming: 16 back-to-back requests with OUT_READY=1 every cycle → 16 deliveries in 16 consecutive cycles, IN_READY constantly 1.
- Out-of-range select (NUM_SRC=3): accept with A_SEL=3 → OP_A=0, SEL_ERR=1 and still 1 after ten further legal requests; RST → SEL_ERR=0.
- Reset in TWO state: fill both entries, assert RST one cycle → OUT_VALID=0, IN_READY=0 during RST, 1 after. No stale pair is ever delivered.
